// File: rtl/door_input_conditioner_if.sv
// door_input_conditioner_if
//   Groups the raw switch inputs and the conditioned outputs of the door
//   input conditioner into one bundle.
//   Raw side (driven by the board / bench):
//     Btn_Raw     - asynchronous push-button level, 1 = pressed
//     UP_Lim_Raw  - asynchronous upper limit switch, 1 = door fully open
//     DN_Lim_Raw  - asynchronous lower limit switch, 1 = door fully closed
//   Conditioned side (driven by the conditioner):
//     Activate    - one-cycle pulse per debounced press
//     UP_Max      - debounced upper limit level
//     DN_Max      - debounced lower limit level
//     Lim_Fault   - both debounced limits closed
//   modport master : drives the raw switches, observes the outputs
//   modport slave  : the conditioner itself
interface door_input_conditioner_if;
  logic Btn_Raw;
  logic UP_Lim_Raw;
  logic DN_Lim_Raw;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic Lim_Fault;

  modport master (
    output Btn_Raw, UP_Lim_Raw, DN_Lim_Raw,
    input  Activate, UP_Max, DN_Max, Lim_Fault
  );

  modport slave (
    input  Btn_Raw, UP_Lim_Raw, DN_Lim_Raw,
    output Activate, UP_Max, DN_Max, Lim_Fault
  );
endinterface

// File: rtl/door_input_conditioner.sv
// door_input_conditioner
//   Synchronises and debounces the wall push-button and the two limit
//   switches for the garage door controller.
//   Ports:
//     CLK - system clock, all logic on the rising edge
//     RST - synchronous active-low reset
//     io  - door_input_conditioner_if.slave (raw switches in, conditioned
//           Activate / UP_Max / DN_Max / Lim_Fault out)
//   Parameter:
//     DEBOUNCE_CYCLES - consecutive synchronised cycles a new level must be
//                       held before the debounced value follows it (>= 1)
module door_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic                      CLK,
  input logic                      RST,
  door_input_conditioner_if.slave  io
);

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = button, 1 = upper limit, 2 = lower limit.
  logic [2:0]       raw;
  logic [2:0]       s1_q;
  logic [2:0]       s2_q;
  logic [2:0]       db_q;
  logic [2:0]       db_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             act_q;
  logic             act_d;
  logic             flt_q;
  logic             flt_d;

  assign raw = {io.DN_Lim_Raw, io.UP_Lim_Raw, io.Btn_Raw};

  always_comb begin
    db_d = db_q;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      cnt_d[ch] = '0;
      if (s2_q[ch] != db_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          db_d[ch] = s2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end
    end
    // Fault and press qualification both look at next-cycle debounced values,
    // so a press landing on the edge a fault clears still produces a pulse.
    flt_d = db_d[1] & db_d[2];
    act_d = db_d[0] & ~db_q[0] & ~flt_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      act_q <= 1'b0;
      flt_q <= 1'b0;
      for (int unsigned ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      db_q  <= db_d;
      act_q <= act_d;
      flt_q <= flt_d;
      for (int unsigned ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign io.Activate  = act_q;
  assign io.UP_Max    = db_q[1];
  assign io.DN_Max    = db_q[2];
  assign io.Lim_Fault = flt_q;

endmodule
